// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the physical-memory port arbiter.
package pmem_arb_pkg;

   localparam int S_OFFSET = 5;
   localparam int S_LINE   = 256;
   localparam int S_ADDR   = 32;

   localparam logic [S_ADDR-1:0] LINE_ADDR_MASK = {{(S_ADDR-S_OFFSET){1'b1}}, {S_OFFSET{1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

endpackage

// File: rtl/pmem_arbiter_chk.sv
// Protocol checks for the shared memory port, observed purely from arbiter ports.
module pmem_arbiter_chk
   import pmem_arb_pkg::*;
(
   input logic              clk,
   input logic              rst,
   input logic              d_pmem_read,
   input logic              d_pmem_write,
   input logic              pmem_read,
   input logic              pmem_write,
   input logic              pmem_resp,
   input logic [S_ADDR-1:0] pmem_address,
   input logic [S_LINE-1:0] pmem_wdata
);

   // A transaction is outstanding exactly when the latched read or write strobe is up.
   a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst)
      !(d_pmem_read && d_pmem_write));

   a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
      pmem_resp |-> (pmem_read || pmem_write));

   a_line_aligned: assert property (@(posedge clk) disable iff (!rst)
      (pmem_address & ~LINE_ADDR_MASK) == {S_ADDR{1'b0}});

   a_busy_stable: assert property (@(posedge clk) disable iff (!rst)
      ((pmem_read || pmem_write) && !pmem_resp) |=>
         ($stable(pmem_address) && $stable(pmem_wdata) && $stable(pmem_read) && $stable(pmem_write)));

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache and D-cache.
module pmem_arbiter
   import pmem_arb_pkg::*;
#(
   parameter int s_offset = S_OFFSET,
   parameter int s_line   = S_LINE,
   parameter int s_addr   = S_ADDR
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [s_addr-1:0] i_pmem_address,
   input  logic              i_pmem_read,
   output logic [s_line-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic [s_addr-1:0] d_pmem_address,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [s_line-1:0] d_pmem_wdata,
   output logic [s_line-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic [s_addr-1:0] pmem_address,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [s_line-1:0] pmem_wdata,
   input  logic [s_line-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam logic [s_addr-1:0] line_mask = {{(s_addr-s_offset){1'b1}}, {s_offset{1'b0}}};

   arb_state_t state_r;
   req_id_t    last_grant_r;
   logic       req_d_s;
   logic       grant_i_s;
   logic       grant_d_s;

   // Pick the winner among current requesters; on a tie the side not served last wins.
   always_comb begin
      req_d_s   = d_pmem_read | d_pmem_write;
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (i_pmem_read && req_d_s) begin
         if (last_grant_r == REQ_D) begin
            grant_i_s = 1'b1;
         end else begin
            grant_d_s = 1'b1;
         end
      end else begin
         grant_i_s = i_pmem_read;
         grant_d_s = req_d_s;
      end
   end

   // Grant FSM and latched command; the latched copy is authoritative until pmem_resp.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         last_grant_r <= REQ_D;
         pmem_address <= {s_addr{1'b0}};
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_wdata   <= {s_line{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_i_s) begin
                  state_r      <= BUSY_I;
                  last_grant_r <= REQ_I;
                  pmem_address <= i_pmem_address & line_mask;
                  pmem_read    <= 1'b1;
                  pmem_write   <= 1'b0;
               end else if (grant_d_s) begin
                  // A write wins if the D side illegally raises both strobes.
                  state_r      <= BUSY_D;
                  last_grant_r <= REQ_D;
                  pmem_address <= d_pmem_address & line_mask;
                  pmem_read    <= ~d_pmem_write;
                  pmem_write   <= d_pmem_write;
                  if (d_pmem_write) begin
                     pmem_wdata <= d_pmem_wdata;
                  end else begin
                     pmem_wdata <= pmem_wdata;
                  end
               end else begin
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (pmem_resp) begin
                  state_r    <= IDLE;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r    <= IDLE;
               pmem_read  <= 1'b0;
               pmem_write <= 1'b0;
            end
         endcase
      end
   end

   assign i_pmem_resp  = pmem_resp && (state_r == BUSY_I);
   assign d_pmem_resp  = pmem_resp && (state_r == BUSY_D);
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: grant order, latching, resp steering and reset abort.
module tb_pmem_arbiter;
   import pmem_arb_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  i_pmem_address = 32'h0;
   logic         i_pmem_read    = 1'b0;
   logic [255:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic [31:0]  d_pmem_address = 32'h0;
   logic         d_pmem_read    = 1'b0;
   logic         d_pmem_write   = 1'b0;
   logic [255:0] d_pmem_wdata   = 256'h0;
   logic [255:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata = 256'h0;
   logic         pmem_resp  = 1'b0;

   int n_pass   = 0;
   int n_checks = 0;

   localparam logic [255:0] PAT_A5 = {32{8'hA5}};
   localparam logic [255:0] PAT_5A = {32{8'h5A}};
   localparam logic [255:0] PAT_W1 = {32{8'h11}};
   localparam logic [255:0] PAT_W2 = {32{8'h22}};
   localparam logic [255:0] RD1    = {8{32'hDEADBEEF}};
   localparam logic [255:0] RD2    = {8{32'h0BADF00D}};
   localparam logic [255:0] RD3    = {8{32'hCAFEF00D}};
   localparam logic [255:0] RD4    = {8{32'h12345678}};

   always #5 clk = ~clk;

   pmem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
      .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   pmem_arbiter_chk chk (
      .clk(clk), .rst(rst),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_resp(pmem_resp), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      // Reset state
      step; step;
      @(negedge clk);
      check("rst_read",  pmem_read,    1'b0);
      check("rst_write", pmem_write,   1'b0);
      check("rst_addr",  pmem_address, 32'h0);
      check("rst_wdata", pmem_wdata,   256'h0);
      check("rst_iresp", i_pmem_resp,  1'b0);
      check("rst_dresp", d_pmem_resp,  1'b0);
      step;
      rst = 1'b1;

      // 1: lone I read, memory answers 3 cycles after grant
      step;
      i_pmem_address = 32'h0000_1234;
      i_pmem_read    = 1'b1;
      @(negedge clk);
      check("t1_read_pre", pmem_read, 1'b0);
      step;
      @(negedge clk);
      check("t1_read", pmem_read,    1'b1);
      check("t1_addr", pmem_address, 32'h0000_1220);
      check("t1_wr",   pmem_write,   1'b0);
      step; step;
      @(negedge clk);
      check("t1_hold", pmem_read, 1'b1);
      check("t1_noresp", i_pmem_resp, 1'b0);
      step;
      pmem_rdata = RD1;
      pmem_resp  = 1'b1;
      @(negedge clk);
      check("t1_iresp",  i_pmem_resp,  1'b1);
      check("t1_dresp",  d_pmem_resp,  1'b0);
      check("t1_irdata", i_pmem_rdata, RD1);
      check("t1_drdata", d_pmem_rdata, RD1);
      step;
      pmem_resp   = 1'b0;
      i_pmem_read = 1'b0;
      @(negedge clk);
      check("t1_iresp_off", i_pmem_resp, 1'b0);
      check("t1_read_off",  pmem_read,   1'b0);

      // 2: tie right after reset -> I, then D after the IDLE gap, next tie -> I
      step;
      rst = 1'b0;
      step;
      rst = 1'b1;
      step;
      i_pmem_address = 32'h0000_0100;
      i_pmem_read    = 1'b1;
      d_pmem_address = 32'h0000_2000;
      d_pmem_read    = 1'b1;
      step;
      @(negedge clk);
      check("t2_first_addr", pmem_address, 32'h0000_0100);
      check("t2_first_read", pmem_read,    1'b1);
      step;
      pmem_rdata = RD2;
      pmem_resp  = 1'b1;
      @(negedge clk);
      check("t2_iresp", i_pmem_resp, 1'b1);
      check("t2_dresp", d_pmem_resp, 1'b0);
      step;
      pmem_resp   = 1'b0;
      i_pmem_read = 1'b0;
      @(negedge clk);
      check("t2_gap_read", pmem_read, 1'b0);
      step;
      @(negedge clk);
      check("t2_second_addr", pmem_address, 32'h0000_2000);
      check("t2_second_read", pmem_read,    1'b1);
      step;
      pmem_resp = 1'b1;
      @(negedge clk);
      check("t2_d_dresp", d_pmem_resp, 1'b1);
      check("t2_d_iresp", i_pmem_resp, 1'b0);
      step;
      pmem_resp      = 1'b0;
      i_pmem_address = 32'h0000_0140;
      i_pmem_read    = 1'b1;
      d_pmem_address = 32'h0000_2040;
      step;
      @(negedge clk);
      check("t2_tie2_addr", pmem_address, 32'h0000_0140);
      step;
      pmem_resp = 1'b1;
      @(negedge clk);
      check("t2_tie2_iresp", i_pmem_resp, 1'b1);
      step;
      pmem_resp   = 1'b0;
      i_pmem_read = 1'b0;
      d_pmem_read = 1'b0;

      // 3: D write, wdata and address latched against mid-transaction changes
      step;
      d_pmem_address = 32'h8000_0040;
      d_pmem_wdata   = PAT_A5;
      d_pmem_write   = 1'b1;
      step;
      @(negedge clk);
      check("t3_write", pmem_write,   1'b1);
      check("t3_read",  pmem_read,    1'b0);
      check("t3_addr",  pmem_address, 32'h8000_0040);
      check("t3_wdata", pmem_wdata,   PAT_A5);
      d_pmem_wdata   = PAT_5A;
      d_pmem_address = 32'h1111_1111;
      step;
      @(negedge clk);
      check("t3_wdata_hold", pmem_wdata,   PAT_A5);
      check("t3_addr_hold",  pmem_address, 32'h8000_0040);
      check("t3_write_hold", pmem_write,   1'b1);
      step;
      pmem_resp = 1'b1;
      @(negedge clk);
      check("t3_dresp", d_pmem_resp, 1'b1);
      check("t3_iresp", i_pmem_resp, 1'b0);
      step;
      pmem_resp    = 1'b0;
      d_pmem_write = 1'b0;
      @(negedge clk);
      check("t3_write_off", pmem_write, 1'b0);

      // 4: D write-back, then D fill, I waiting -> D(write), I, D(read)
      step;
      d_pmem_address = 32'h0000_0300;
      d_pmem_wdata   = PAT_W1;
      d_pmem_write   = 1'b1;
      step;
      @(negedge clk);
      check("t4_wb_write", pmem_write,   1'b1);
      check("t4_wb_addr",  pmem_address, 32'h0000_0300);
      i_pmem_address = 32'h0000_0440;
      i_pmem_read    = 1'b1;
      step;
      pmem_resp = 1'b1;
      @(negedge clk);
      check("t4_wb_dresp", d_pmem_resp, 1'b1);
      check("t4_wb_iresp", i_pmem_resp, 1'b0);
      step;
      pmem_resp      = 1'b0;
      d_pmem_write   = 1'b0;
      d_pmem_address = 32'h0000_0580;
      d_pmem_read    = 1'b1;
      @(negedge clk);
      check("t4_gap_busy", {pmem_read, pmem_write}, 2'b00);
      step;
      @(negedge clk);
      check("t4_i_addr", pmem_address, 32'h0000_0440);
      check("t4_i_read", pmem_read,    1'b1);
      step;
      pmem_rdata = RD3;
      pmem_resp  = 1'b1;
      @(negedge clk);
      check("t4_i_iresp", i_pmem_resp, 1'b1);
      check("t4_i_dresp", d_pmem_resp, 1'b0);
      step;
      pmem_resp   = 1'b0;
      i_pmem_read = 1'b0;
      @(negedge clk);
      check("t4_gap2_read", pmem_read, 1'b0);
      step;
      @(negedge clk);
      check("t4_fill_addr", pmem_address, 32'h0000_0580);
      check("t4_fill_rw",   {pmem_read, pmem_write}, 2'b10);
      check("t4_fill_wdata", pmem_wdata, PAT_W1);
      step;
      pmem_rdata = RD4;
      pmem_resp  = 1'b1;
      @(negedge clk);
      check("t4_fill_dresp",  d_pmem_resp,  1'b1);
      check("t4_fill_iresp",  i_pmem_resp,  1'b0);
      check("t4_fill_drdata", d_pmem_rdata, RD4);
      step;
      pmem_resp   = 1'b0;
      d_pmem_read = 1'b0;

      // 5: reset during BUSY_D abandons the write, then a fresh I read is served
      step;
      d_pmem_address = 32'h0000_0900;
      d_pmem_wdata   = PAT_W2;
      d_pmem_write   = 1'b1;
      step;
      @(negedge clk);
      check("t5_busy_write", pmem_write, 1'b1);
      step;
      rst          = 1'b0;
      d_pmem_write = 1'b0;
      pmem_resp    = 1'b1;
      #1;
      check("t5_rst_write", pmem_write,   1'b0);
      check("t5_rst_addr",  pmem_address, 32'h0);
      check("t5_rst_dresp", d_pmem_resp,  1'b0);
      step;
      pmem_resp = 1'b0;
      step;
      rst = 1'b1;
      @(negedge clk);
      check("t5_post_idle", {pmem_read, pmem_write}, 2'b00);
      i_pmem_address = 32'h0000_ABCD;
      i_pmem_read    = 1'b1;
      step;
      @(negedge clk);
      check("t5_i_addr", pmem_address, 32'h0000_ABC0);
      check("t5_i_read", pmem_read,    1'b1);
      step;
      pmem_resp = 1'b1;
      @(negedge clk);
      check("t5_i_iresp", i_pmem_resp, 1'b1);
      check("t5_i_dresp", d_pmem_resp, 1'b0);
      step;
      pmem_resp   = 1'b0;
      i_pmem_read = 1'b0;
      step;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
